// File: rtl/uart_block_serializer_tx.sv
// Word-to-UART serializer: splits a blockSize-byte word into 8N1/8N2 frames, LSB first, fractional baud; even parity with UART_TX_PARITY_EN.
// Latency: start bit appears on uart one clk after the accept edge; bytes of a word are sent with no idle gap.
// Backpressure: inReady low from accept until the final stop bit ends; inValid while busy is dropped, not queued.
module uart_block_serializer_tx #(
    parameter int clockRate = 76_800_000,
    parameter int uartRate  = 12_000_000,
    parameter int blockSize = 3,
    parameter int stopBits  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inValid,
    input  logic [8*blockSize-1:0] inData,
    output logic                   inReady,
    output logic                   uart,
    output logic                   busy
);

    localparam int AccW  = $clog2(clockRate) + 1;
    localparam int ByteW = (blockSize > 1) ? $clog2(blockSize) : 1;

    localparam logic [ByteW-1:0] lastByte  = ByteW'(blockSize - 1);
    localparam logic             lastStop  = 1'(stopBits - 1);
    localparam logic [AccW:0]    rateInc   = (AccW + 1)'(uartRate);
    localparam logic [AccW:0]    clockLim  = (AccW + 1)'(clockRate);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]             state;
    logic [AccW-1:0]        acc;
    logic [AccW:0]          accSum;
    logic [AccW-1:0]        accNext;
    logic                   tick;
    logic [8*blockSize-1:0] shiftReg;
    logic [2:0]             bitCnt;
    logic [ByteW-1:0]       byteCnt;
    logic                   stopCnt;
    logic                   lineBit;
`ifdef UART_TX_PARITY_EN
    logic                   parBit;
`endif

    // Remainder stays below clockRate, so one extra bit holds the sum without overflow.
    always_comb begin
        accSum  = {1'b0, acc} + rateInc;
        tick    = (accSum >= clockLim);
        accNext = tick ? AccW'(accSum - clockLim) : AccW'(accSum);
    end

    always_comb begin
        lineBit = 1'b1;
        case (state)
            START:   lineBit = 1'b0;
            DATA:    lineBit = shiftReg[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  lineBit = parBit;
`endif
            default: lineBit = 1'b1;
        endcase
    end

    assign inReady = (state == IDLE);
    assign busy    = ~inReady;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            acc      <= '0;
            shiftReg <= '0;
            bitCnt   <= '0;
            byteCnt  <= '0;
            stopCnt  <= 1'b0;
            uart     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parBit   <= 1'b0;
`endif
        end else begin
            uart <= lineBit;
            acc  <= accNext;
            case (state)
                IDLE: begin
                    if (inValid) begin
                        shiftReg <= inData;
                        acc      <= '0;
                        byteCnt  <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        state  <= DATA;
                        bitCnt <= '0;
`ifdef UART_TX_PARITY_EN
                        parBit <= ^shiftReg[7:0];
`endif
                    end
                end
                DATA: begin
                    // The whole word shifts, so the next byte lands in bits [7:0] after bit 7.
                    if (tick) begin
                        shiftReg <= shiftReg >> 1;
                        bitCnt   <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
                            stopCnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (stopCnt == lastStop) begin
                            stopCnt <= 1'b0;
                            if (byteCnt == lastByte) begin
                                state <= IDLE;
                            end else begin
                                byteCnt <= byteCnt + 1'b1;
                                state   <= START;
                            end
                        end else begin
                            stopCnt <= stopCnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_block_serializer_tx.sv
// Bench for uart_block_serializer_tx: scoreboard of expected frames on a 16 clk/bit instance,
// plus timing measurement on a default-rate instance.
module tb_uart_block_serializer_tx;

`ifdef UART_TX_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int G = BITS * 16;

    typedef struct {
        logic [7:0] b;
        logic       p;
        int         gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstA = 1'b0;
    logic        inValidA = 1'b0;
    logic [23:0] inDataA = '0;
    logic        inReadyA, uartA, busyA;
    logic        rstB = 1'b0;
    logic        inValidB = 1'b0;
    logic [799:0] inDataB = '0;
    logic        inReadyB, uartB, busyB;

    int   cyc = 0;
    int   nCmp = 0;
    int   nBad = 0;
    bit   ignore = 1'b0;
    bit   bDone = 1'b0;
    exp_t expQ[$];

    uart_block_serializer_tx #(.clockRate(16), .uartRate(1), .blockSize(3), .stopBits(1)) dutA (
        .clk(clk), .reset(rstA), .inValid(inValidA), .inData(inDataA),
        .inReady(inReadyA), .uart(uartA), .busy(busyA)
    );

    uart_block_serializer_tx #(.blockSize(100)) dutB (
        .clk(clk), .reset(rstB), .inValid(inValidB), .inData(inDataB),
        .inReady(inReadyB), .uart(uartB), .busy(busyB)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        nCmp++;
        if (act != exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", nm, act, act, exp, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic p, input int gap);
        exp_t e;
        e.b = b;
        e.p = p;
        e.gap = gap;
        expQ.push_back(e);
    endtask

    // Counts negedges until inReadyA is seen high; a hang shows up as a wrong count.
    task automatic waitReady(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inReadyA && n < 3000);
    endtask

    // Line monitor for instance A: decodes each frame and checks it against the scoreboard.
    initial begin : monA
        logic prev;
        int   lastT0;
        prev = 1'b1;
        lastT0 = -1;
        forever begin
            @(negedge clk);
            if (rstA && !ignore && prev && !uartA) begin : frame
                int          t0;
                int          bad;
                exp_t        e;
                logic [BITS-1:0] bits;
                logic [7:0]  got;
                t0 = cyc;
                if (expQ.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    e.b = 8'h00; e.p = 1'b0; e.gap = 0;
                end else begin
                    e = expQ.pop_front();
                end
`ifdef UART_TX_PARITY_EN
                bits = {1'b1, e.p, e.b, 1'b0};
`else
                bits = {1'b1, e.b, 1'b0};
`endif
                if (e.gap != 0 && lastT0 >= 0) chk("frame_gap", t0 - lastT0, e.gap);
                lastT0 = t0;
                bad = 0;
                got = '0;
                for (int k = 0; k < G; k++) begin
                    if (k > 0) @(negedge clk);
                    if (uartA !== bits[k/16]) bad++;
                    if (k % 16 == 8 && k / 16 >= 1 && k / 16 <= 8) got[k/16-1] = uartA;
                end
                chk("frame_line", bad, 0);
                chk("frame_byte", got, e.b);
            end
            prev = uartA;
        end
    end

    // Default-rate instance: 100 bytes of 0x55 make the line toggle every bit period.
    int trT[1100];
    initial begin : procB
        int n, tReady, badLen, span;
        logic prev;
        inDataB = {100{8'h55}};
        repeat (5) @(negedge clk);
        rstB = 1'b1;
`ifndef UART_TX_PARITY_EN
        @(negedge clk);
        inValidB = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValidB = 1'b0;
        prev = uartB;
        n = 0;
        tReady = -1;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            if (uartB != prev && n < 1100) begin
                trT[n] = cyc;
                n++;
            end
            prev = uartB;
            if (inReadyB) begin
                tReady = cyc;
                break;
            end
        end
        chk("b_done", (tReady >= 0), 1);
        chk("b_transitions", n, 1000);
        badLen = 0;
        for (int i = 1; i < n; i++)
            if (trT[i] - trT[i-1] != 6 && trT[i] - trT[i-1] != 7) badLen++;
        if (n > 0 && (tReady + 1 - trT[n-1] != 6) && (tReady + 1 - trT[n-1] != 7)) badLen++;
        chk("b_bit_lengths", badLen, 0);
        span = (n > 0) ? (tReady + 1 - trT[0]) : 0;
        chk("b_span_in_6399_6401", (span >= 6399 && span <= 6401) ? 6400 : span, 6400);
`endif
        bDone = 1'b1;
    end

    initial begin : mainA
        int n, bad;
        repeat (3) @(negedge clk);
        chk("rst_uart", uartA, 1);
        chk("rst_inReady", inReadyA, 1);
        chk("rst_busy", busyA, 0);
        rstA = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!(uartA === 1'b1 && inReadyA === 1'b1 && busyA === 1'b0)) bad++;
        end
        chk("idle_hold", bad, 0);

        // Single word 0x0000A5; source data scrambled after accept.
        push(8'hA5, 1'b0, 0); push(8'h00, 1'b0, G); push(8'h00, 1'b0, G);
        inValidA = 1'b1;
        inDataA = 24'h0000A5;
        @(posedge clk);
        @(negedge clk);
        inValidA = 1'b0;
        inDataA = 24'hFFFFFF;
        chk("accept_inReady", inReadyA, 0);
        chk("accept_busy", busyA, 1);
        chk("accept_uart_still_idle", uartA, 1);
        waitReady(n);
        chk("single_ready_delay", n, 3 * G);
        chk("single_busy_end", busyA, 0);
        repeat (20) @(negedge clk);

        // Back-to-back words with inValid held high throughout.
        push(8'h56, 1'b0, 0); push(8'h34, 1'b1, G); push(8'h12, 1'b0, G);
        push(8'hEF, 1'b1, G + 1); push(8'hCD, 1'b1, G); push(8'hAB, 1'b1, G);
        inValidA = 1'b1;
        inDataA = 24'h123456;
        @(posedge clk);
        @(negedge clk);
        inDataA = 24'hABCDEF;
        waitReady(n);
        chk("b2b_ready1_delay", n, 3 * G);
        @(posedge clk);
        @(negedge clk);
        inValidA = 1'b0;
        chk("b2b_accept2", inReadyA, 0);
        waitReady(n);
        chk("b2b_ready2_delay", n, 3 * G);
        repeat (100) @(negedge clk);
        chk("b2b_queue_drained", expQ.size(), 0);

        // Reset during data bit 3 of byte 1 (byte 1 is 0x00, so the line is low there).
        @(posedge clk);
        ignore = 1'b1;
        @(negedge clk);
        inValidA = 1'b1;
        inDataA = 24'hC30096;
        @(posedge clk);
        @(negedge clk);
        inValidA = 1'b0;
        repeat (G + 72 - 1) @(negedge clk);
        chk("mid_bit_low", uartA, 0);
        chk("mid_busy", busyA, 1);
        rstA = 1'b0;
        @(negedge clk);
        chk("midrst_uart", uartA, 1);
        chk("midrst_inReady", inReadyA, 1);
        chk("midrst_busy", busyA, 0);
        rstA = 1'b1;
        repeat (20) @(negedge clk);
        @(posedge clk);
        ignore = 1'b0;
        push(8'hE7, 1'b0, 0); push(8'h81, 1'b0, G); push(8'h3C, 1'b0, G);
        @(negedge clk);
        inValidA = 1'b1;
        inDataA = 24'h3C81E7;
        @(posedge clk);
        @(negedge clk);
        inValidA = 1'b0;
        waitReady(n);
        chk("post_rst_ready_delay", n, 3 * G);
        repeat (20) @(negedge clk);

`ifdef UART_TX_PARITY_EN
        push(8'h07, 1'b1, 0); push(8'h03, 1'b0, G); push(8'h00, 1'b0, G);
        inValidA = 1'b1;
        inDataA = 24'h000307;
        @(posedge clk);
        @(negedge clk);
        inValidA = 1'b0;
        waitReady(n);
        chk("parity_ready_delay", n, 528);
        repeat (20) @(negedge clk);
`endif

        repeat (50) @(negedge clk);
        chk("queue_empty", expQ.size(), 0);
        n = 0;
        while (!bDone && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk("b_finished", bDone, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
